// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the shared register-file write port.
// The master side presents requests; the slave side grants them and drives the write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned XLEN    = 32
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*5-1:0]    req_rd;
    logic [NUM_REQ*XLEN-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    RegWrite;
    logic [4:0]              RD;
    logic [XLEN-1:0]         WriteData;

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, RegWrite, RD, WriteData
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, RegWrite, RD, WriteData
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources,
// with a registered write stage and a 32-entry pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned XLEN    = 32
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave wb,
    input  logic                sb_set_valid,
    input  logic [4:0]          sb_set_rd,
    input  logic                sb_flush,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                sb_any_busy
);
    localparam int unsigned PtrW = $clog2(NUM_REQ);

    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [PtrW-1:0]    grant_idx, cand;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant;

    logic [4:0]         rd_arr   [NUM_REQ];
    logic [XLEN-1:0]    data_arr [NUM_REQ];

    logic               regwrite_q;
    logic [4:0]         rd_q;
    logic [XLEN-1:0]    wdata_q;
    logic [31:0]        pending_q, pending_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rd_arr[g]   = wb.req_rd[5*g +: 5];
        assign data_arr[g] = wb.req_data[XLEN*g +: XLEN];
    end

    // Search upward from ptr, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_any) begin
                cand = PtrW'((32'(ptr_q) + k) % NUM_REQ);
                if (wb.req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign wb.req_ready = grant;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Clear on writeback, then set, then flush: set beats a same-register clear,
    // flush beats everything.
    always_comb begin
        pending_d = pending_q;
        if (regwrite_q) begin
            pending_d[rd_q] = 1'b0;
        end
        if (sb_set_valid && (sb_set_rd != 5'd0)) begin
            pending_d[sb_set_rd] = 1'b1;
        end
        if (sb_flush) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            pending_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            if (grant_any) begin
                rd_q       <= rd_arr[grant_idx];
                wdata_q    <= data_arr[grant_idx];
                regwrite_q <= (rd_arr[grant_idx] != 5'd0);
            end else begin
                regwrite_q <= 1'b0;
            end
        end
    end

    assign wb.RegWrite  = regwrite_q;
    assign wb.RD        = rd_q;
    assign wb.WriteData = wdata_q;

    assign rs1_busy    = pending_q[rs1];
    assign rs2_busy    = pending_q[rs2];
    assign sb_any_busy = |pending_q;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback sources (e.g. ALU, load unit, mul/div).
- Arbitration is round-robin. The winning request is registered into one write stage that drives RegWrite/RD/WriteData of the register file.
- Also keeps a 32-entry pending-write scoreboard. Issue logic uses it to stall reads of registers whose producers have not yet written back.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width of the write port

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  requester i has a write pending
- req_rd  in  NUM_REQ*5  destination register of requester i, slice [5i+4:5i]
- req_data  in  NUM_REQ*XLEN  write data of requester i, slice [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  NUM_REQ  one-hot grant; the transfer happens when req_valid[i] && req_ready[i]
- RegWrite  out  1  write enable to register file
- RD  out  5  write address to register file
- WriteData  out  XLEN  write data to register file
- sb_set_valid  in  1  issue stage marks a register as pending
- sb_set_rd  in  5  register to mark pending
- sb_flush  in  1  clear all pending bits (pipeline flush)
- rs1  in  5  query address 1
- rs2  in  5  query address 2
- rs1_busy  out  1  pending[rs1], combinational
- rs2_busy  out  1  pending[rs2], combinational
- sb_any_busy  out  1  OR of all pending bits

Behaviour:
- Reset (rst=1 at a clk edge):
  - RegWrite=0, RD=0, WriteData=0.
  - Pending vector = 0.
  - Round-robin pointer = 0.
  - req_ready is still computed combinationally but no accepted transfer updates state in that cycle; all other state is held at reset values.
- Arbitration (combinational):
  - Starting at index ptr and searching upward modulo NUM_REQ, the first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
  - No valid request -> req_ready=0.
  - req_ready never depends on RegWrite; the write port accepts one write every cycle.
- Pointer update: when a grant occurs at a clk edge, ptr <= (granted index + 1) mod NUM_REQ. With no grant, ptr holds.
- Write stage (1-cycle latency): a grant in cycle N produces RD=req_rd, WriteData=req_data in cycle N+1.
  - RegWrite=1 in N+1 only if req_rd != 0.
  - A granted request with rd=0 is consumed (ready=1) but RegWrite=0.
  - With no grant in N, RegWrite=0 in N+1; RD/WriteData hold their previous values.
- Scoreboard:
  - pending[r] set at the edge when sb_set_valid=1 and sb_set_rd=r, r != 0.
  - pending[r] cleared at the edge ending a cycle in which RegWrite=1 and RD=r.
  - Set and clear of the same r at the same edge -> set wins (newer producer outstanding).
  - sb_flush=1 -> all bits cleared at the edge. The write stage still completes its current write. sb_flush takes priority over a simultaneous set.
  - pending[0] is constant 0. rs1=0 or rs2=0 always reads busy=0.
  - Busy is still 1 during the cycle RegWrite is asserted for that register; it deasserts the following cycle.
- Stability: requesters must hold req_valid/req_rd/req_data until granted. The block does not buffer unaccepted requests.
- Reset mid-operation: a write registered in the stage is discarded (RegWrite=0 the next cycle) and the pointer returns to 0.

Test Plan:
- Reset, then all req_valid=0 for 5 cycles -> RegWrite=0, req_ready=0, sb_any_busy=0 throughout.
- Single requester 1 presents rd=5, data=0xDEADBEEF for one cycle -> req_ready=3'b010 that cycle; next cycle RegWrite=1, RD=5, WriteData=0xDEADBEEF; following cycle RegWrite=0.
- All three requesters valid continuously for 6 cycles after reset (rd=1,2,3) -> grant order 0,1,2,0,1,2; RD sequence 1,2,3,1,2,3 one cycle later; no requester is granted twice while another is waiting.
- Scoreboard: sb_set rd=7, then requester 2 writes rd=7 three cycles later -> rs1=7 busy from the cycle after set through the RegWrite cycle; busy=0 the cycle after; simultaneous set rd=7 with a RegWrite to RD=7 leaves busy=1.
- Requester 0 writes rd=0 with data=0x1234 -> req_ready[0]=1, RegWrite stays 0; sb_set rd=0 leaves sb_any_busy=0.
- Set rd=3 and rd=9, assert sb_flush together with sb_set rd=12 -> all busy=0 next cycle; rst asserted the cycle after a grant -> RegWrite=0 next cycle and the next contested grant goes to index 0.
